// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage: SRAM bus width, default
// base address and the half-word transfer FSM encoding.
package arm_pkg;

  localparam int unsigned SRAM_DATA_W       = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Word access to a 16-bit SRAM as two half-word phases (low, then high), each held
// on the bus for WAIT_CYCLES cycles; captures read data into a 32-bit register.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   wr_i,
  input  logic [SRAM_ADDR_W-2:0] idx_i,
  input  logic [31:0]            wdata_i,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [SRAM_DATA_W-1:0] sram_dq_out_o,
  output logic                   sram_dq_oe_o,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in_i,
  output logic                   sram_we_n_o
);

  localparam int unsigned     CntW    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  sram_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            last;

  assign last = (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    sram_addr_o   = '0;
    sram_dq_out_o = '0;
    sram_dq_oe_o  = 1'b0;
    sram_we_n_o   = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StLo;
          cnt_d   = '0;
        end
      end
      StLo: begin
        sram_addr_o   = {idx_i, 1'b0};
        sram_dq_out_o = wdata_i[15:0];
        sram_dq_oe_o  = wr_i;
        // Strobe released on the final cycle so address/data outlast we_n.
        sram_we_n_o   = ~(wr_i & ~last);
        if (last) begin
          state_d = StHi;
          cnt_d   = '0;
          if (!wr_i) rdata_d[15:0] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHi: begin
        sram_addr_o   = {idx_i, 1'b1};
        sram_dq_out_o = wdata_i[31:16];
        sram_dq_oe_o  = wr_i;
        sram_we_n_o   = ~(wr_i & ~last);
        if (last) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_i) rdata_d[31:16] = sram_dq_in_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = (state_q == StDone);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_sram.sv
// Pipeline memory stage: maps byte addresses onto SRAM word slots, stalls the
// pipeline while an LDR/STR is in flight and passes EXE/MEM fields to MEM/WB.
module mem_stage_sram
  import arm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WB_EN,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_Rm,
  input  logic [3:0]             Dest,
  output logic                   ready,
  output logic                   WB_EN_out,
  output logic                   MEM_R_EN_out,
  output logic [31:0]            ALU_Res_out,
  output logic [3:0]             Dest_out,
  output logic [31:0]            Mem_Data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  logic [31:0]            off;
  logic [SRAM_ADDR_W-2:0] idx;
  logic                   req;
  logic                   done;
  logic                   unused_off;

  // Offset wraps modulo 2^32; byte-within-word bits are dropped.
  assign off        = ALU_Res - BASE_ADDR;
  assign idx        = off[SRAM_ADDR_W:2];
  assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

  assign req   = MEM_R_EN | MEM_W_EN;
  assign ready = ~req | done;

  assign WB_EN_out    = WB_EN;
  assign MEM_R_EN_out = MEM_R_EN;
  assign ALU_Res_out  = ALU_Res;
  assign Dest_out     = Dest;

  sram_ctrl #(
    .SRAM_ADDR_W (SRAM_ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_sram_ctrl (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .wr_i          (MEM_W_EN),
    .idx_i         (idx),
    .wdata_i       (Val_Rm),
    .done_o        (done),
    .rdata_o       (Mem_Data),
    .sram_addr_o   (sram_addr),
    .sram_dq_out_o (sram_dq_out),
    .sram_dq_oe_o  (sram_dq_oe),
    .sram_dq_in_i  (sram_dq_in),
    .sram_we_n_o   (sram_we_n)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: a word-level reference memory predicts each
// access; a monitor checks load data, stored SRAM contents and bus activity.
module tb_mem_stage_sram;

  localparam int unsigned W    = 2;
  localparam int unsigned AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic          clk, rst;
  logic          WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0]   ALU_Res, Val_Rm;
  logic [3:0]    Dest;
  logic          ready, WB_EN_out, MEM_R_EN_out;
  logic [31:0]   ALU_Res_out, Mem_Data;
  logic [3:0]    Dest_out;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  mem_stage_sram #(
    .BASE_ADDR   (BASE),
    .SRAM_ADDR_W (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN        (WB_EN),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .ALU_Res      (ALU_Res),
    .Val_Rm       (Val_Rm),
    .Dest         (Dest),
    .ready        (ready),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_Res_out  (ALU_Res_out),
    .Dest_out     (Dest_out),
    .Mem_Data     (Mem_Data),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_dq_in   (sram_dq_in),
    .sram_we_n    (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRAM device.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram_mem[sram_addr];

  typedef struct {
    logic        is_wr;
    logic [16:0] idx;
    logic [31:0] data;
    logic [31:0] mem_data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_words [int unsigned];
  logic [31:0] exp_md;
  int          checks, errors;
  int          we_lo, oe_hi;
  bit          rec;
  bit          trace[$];

  function automatic logic [15:0] pre_half(int unsigned a);
    return 16'((a * 32'd40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [16:0] word_idx(logic [31:0] alu);
    logic [31:0] o;
    o = (alu - BASE) >> 2;
    return o[16:0];
  endfunction

  function automatic logic [31:0] ref_word(logic [16:0] i);
    int unsigned k;
    k = int'(i);
    if (ref_words.exists(k)) return ref_words[k];
    return {pre_half(2*k+1), pre_half(2*k)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever a memory op completes.
  always @(negedge clk) begin
    exp_t e;
    if (rec) trace.push_back(ready);
    if (rst) begin
      we_lo = 0;
      oe_hi = 0;
    end else begin
      if (sram_we_n === 1'b0) we_lo++;
      if (sram_dq_oe === 1'b1) oe_hi++;
      if (ready && (MEM_R_EN || MEM_W_EN)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mem_data", Mem_Data, e.mem_data);
          check("we_n_low_cycles", we_lo, e.is_wr ? 2*(W-1) : 0);
          check("oe_cycles", oe_hi, e.is_wr ? 2*W : 0);
          if (e.is_wr)
            check("sram_word", {sram_mem[{e.idx, 1'b1}], sram_mem[{e.idx, 1'b0}]}, e.data);
        end
        we_lo = 0;
        oe_hi = 0;
      end
    end
  end

  task automatic issue(bit wb, bit r, bit w, logic [31:0] alu, logic [31:0] val,
                       logic [3:0] dst);
    exp_t e;
    @(posedge clk);
    #1;
    WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w; ALU_Res = alu; Val_Rm = val; Dest = dst;
    if (r || w) begin
      e.is_wr = w;
      e.idx   = word_idx(alu);
      e.data  = val;
      if (w) ref_words[int'(e.idx)] = val;
      else   exp_md = ref_word(e.idx);
      e.mem_data = exp_md;
      sb.push_back(e);
    end
  endtask

  task automatic do_op(bit wb, bit r, bit w, logic [31:0] alu, logic [31:0] val,
                       logic [3:0] dst);
    int n;
    issue(wb, r, w, alu, val, dst);
    if (r || w) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ready && n < 20);
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
    end else begin
      #1;
      check("pt_ready", ready, 1'b1);
      check("pt_wb_en", WB_EN_out, wb);
      check("pt_mem_r_en", MEM_R_EN_out, r);
      check("pt_alu_res", ALU_Res_out, alu);
      check("pt_dest", Dest_out, dst);
    end
  endtask

  // Cycle-by-cycle bus check: idle cycle, W low-half cycles, W high-half cycles, done.
  task automatic directed_bus(bit r, bit w, logic [31:0] alu, logic [31:0] val);
    logic [16:0] i;
    i = word_idx(alu);
    issue(1'b0, r, w, alu, val, 4'd0);
    for (int c = 0; c <= 2*W+1; c++) begin
      bit in_lo, in_hi;
      int k;
      @(negedge clk);
      in_lo = (c >= 1) && (c <= W);
      in_hi = (c > W) && (c <= 2*W);
      k     = in_lo ? c - 1 : c - W - 1;
      check($sformatf("bus_c%0d_ready", c), ready, c == 2*W+1);
      if (in_lo || in_hi) begin
        check($sformatf("bus_c%0d_addr", c), sram_addr, {i, in_hi});
        check($sformatf("bus_c%0d_oe", c), sram_dq_oe, w);
        check($sformatf("bus_c%0d_we_n", c), sram_we_n, !(w && k != W-1));
        if (w) check($sformatf("bus_c%0d_dq", c), sram_dq_out,
                     in_hi ? val[31:16] : val[15:0]);
      end else begin
        check($sformatf("bus_c%0d_oe", c), sram_dq_oe, 1'b0);
        check($sformatf("bus_c%0d_we_n", c), sram_we_n, 1'b1);
      end
    end
  endtask

  initial begin
    int first0, last0, ones, n;
    checks = 0; errors = 0; exp_md = 32'd0; rec = 1'b0;
    for (int a = 0; a < (1 << AW); a++) sram_mem[a] = pre_half(a);
    rst = 1'b1; WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_Res = 0; Val_Rm = 0; Dest = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset during the low phase of a store.
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; ALU_Res = BASE + 32'd64; Val_Rm = 32'h1234_5678;
    @(posedge clk); #1;
    check("pre_rst_we_n", sram_we_n, 1'b0);
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    check("rst_same_edge_we_n", sram_we_n, 1'b1);
    @(posedge clk); #1;
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe", sram_dq_oe, 1'b0);
    check("rst_addr", sram_addr, 18'd0);
    check("rst_mem_data", Mem_Data, 32'd0);
    check("rst_no_hi_write", sram_mem[33], pre_half(33));
    rst = 1'b0;

    directed_bus(1'b0, 1'b1, BASE, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b1, 1'b0, BASE, 32'd0, 4'd1);
    check("ldr_deadbeef", Mem_Data, 32'hDEAD_BEEF);
    directed_bus(1'b1, 1'b0, BASE + 32'd6, 32'd0);
    directed_bus(1'b1, 1'b1, BASE + 32'd8, 32'hCAFE_F00D);
    check("both_en_md_kept", Mem_Data, ref_word(word_idx(BASE + 32'd6)));
    do_op(1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd5);

    // Back-to-back loads: exactly one ready cycle between stall windows.
    trace.delete();
    rec = 1'b1;
    do_op(1'b1, 1'b1, 1'b0, BASE + 32'd8, 32'd0, 4'd2);
    do_op(1'b1, 1'b1, 1'b0, BASE, 32'd0, 4'd3);
    rec = 1'b0;
    first0 = -1; last0 = -1; ones = 0;
    foreach (trace[j]) if (!trace[j]) begin
      if (first0 < 0) first0 = j;
      last0 = j;
    end
    for (int j = first0 + 1; j < last0; j++) if (trace[j]) ones++;
    check("b2b_ready_gap", ones, 1);

    for (int t = 0; t < 80; t++) begin
      int unsigned kind;
      logic [31:0] alu;
      kind = $urandom_range(0, 9);
      alu  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                         : BASE + 32'd256 + 32'($urandom_range(0, 127));
      if (kind < 2)      do_op(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
      else if (kind < 6) do_op(1'b1, 1'b1, 1'b0, alu, $urandom, 4'($urandom));
      else if (kind < 9) do_op(1'b0, 1'b0, 1'b1, alu, $urandom, 4'($urandom));
      else               do_op(1'b0, 1'b1, 1'b1, alu, $urandom, 4'($urandom));
    end

    @(posedge clk); #1;
    MEM_R_EN = 0; MEM_W_EN = 0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
